// File: rtl/sd_cmd_pkg.sv
// Shared types and constants for the SD host CMD physical layer.
package sd_cmd_pkg;

    typedef enum logic [5:0] {
        ST_IDLE      = 6'b000001,
        ST_SEND      = 6'b000010,
        ST_WAIT_RESP = 6'b000100,
        ST_RECV      = 6'b001000,
        ST_NCC_WAIT  = 6'b010000,
        ST_DONE      = 6'b100000
    } cmd_state_t;

    localparam logic [1:0] RESP_NONE  = 2'b00;
    localparam logic [1:0] RESP_SHORT = 2'b01;
    localparam logic [1:0] RESP_LONG  = 2'b10;

    localparam int unsigned CMD_BODY_LEN  = 40;
    localparam int unsigned CMD_FRAME_LEN = 48;
    localparam int unsigned LONG_RESP_LEN = 136;

    localparam logic [6:0] CRC7_POLY = 7'h09;

    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
        logic fb;
        fb = bit_in ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

    // Number of response bits on the wire; type 11 is handled as short.
    function automatic logic [7:0] resp_len(input logic [1:0] resp_type);
        case (resp_type)
            RESP_SHORT: return 8'(CMD_FRAME_LEN);
            RESP_LONG:  return 8'(LONG_RESP_LEN);
            default:    return 8'(CMD_FRAME_LEN);
        endcase
    endfunction

endpackage

// File: rtl/crc7_serial.sv
// Bit-serial CRC7 (x^7 + x^3 + 1) accumulator, MSB first, init 0.
module crc7_serial
    import sd_cmd_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    input  logic       bit_in,
    output logic [6:0] crc
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            crc <= '0;
        end else if (clear) begin
            // clear restarts the CRC and may absorb the first bit in the same cycle
            crc <= enable ? crc7_step(7'h00, bit_in) : 7'h00;
        end else if (enable) begin
            crc <= crc7_step(crc, bit_in);
        end
    end

endmodule

// File: rtl/cmd_phys.sv
// SD host CMD line PHY: sends 48-bit command frames, receives 48/136-bit responses.
// Define RESP_CRC_CHECK_EN to build the response CRC7 check (crc_error).
module cmd_phys
    import sd_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned NCC_CYCLES     = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         strobe_in,
    input  logic         ack_in,
    input  logic         idle_in,
    input  logic [39:0]  cmd_to_send,
    input  logic [1:0]   resp_type,
    input  logic         timeout_enable,
    input  logic         cmd_pin_in,
    output logic         cmd_pin_out,
    output logic         cmd_pin_oe,
    output logic         ack_out,
    output logic         strobe_out,
    output logic [127:0] cmd_response,
    output logic         time_out,
    output logic         crc_error
);

    localparam int unsigned WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] TX_BODY_LAST = 8'(CMD_BODY_LEN - 1);
    localparam logic [7:0] TX_END_IDX   = 8'(CMD_FRAME_LEN - 2);
    localparam logic [7:0] TX_LAST      = 8'(CMD_FRAME_LEN - 1);
    localparam logic [7:0] NCC_LAST     = 8'(NCC_CYCLES - 1);

    cmd_state_t        state;
    logic [38:0]       tx_shift;
    logic [7:0]        bit_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              resp_none_q;
    logic              timeout_en_q;
    logic [7:0]        rx_last;
    logic [126:0]      rx_shift;

    logic              accept;
    logic              rx_done;
    logic [127:0]      rx_frame;
    logic              tx_crc_en;
    logic              tx_crc_bit;
    logic [6:0]        tx_crc;
    logic [2:0]        crc_idx;

    assign accept     = (state == ST_IDLE) && strobe_in && !idle_in;
    assign rx_frame   = {rx_shift, cmd_pin_in};
    assign rx_done    = (state == ST_RECV) && (bit_cnt == rx_last);
    assign tx_crc_en  = accept || ((state == ST_SEND) && (bit_cnt < TX_BODY_LAST));
    assign tx_crc_bit = accept ? cmd_to_send[39] : tx_shift[38];
    assign crc_idx    = 3'(8'd45 - bit_cnt);

    crc7_serial u_tx_crc (
        .clock  (clock),
        .reset  (reset),
        .clear  (accept),
        .enable (tx_crc_en),
        .bit_in (tx_crc_bit),
        .crc    (tx_crc)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            cmd_pin_out  <= 1'b1;
            cmd_pin_oe   <= 1'b0;
            ack_out      <= 1'b0;
            strobe_out   <= 1'b0;
            cmd_response <= '0;
            time_out     <= 1'b0;
            tx_shift     <= '0;
            bit_cnt      <= '0;
            wait_cnt     <= '0;
            resp_none_q  <= 1'b0;
            timeout_en_q <= 1'b0;
            rx_last      <= '0;
            rx_shift     <= '0;
        end else begin
            ack_out <= 1'b0;
            if (idle_in) begin
                state       <= ST_IDLE;
                cmd_pin_oe  <= 1'b0;
                cmd_pin_out <= 1'b1;
                strobe_out  <= 1'b0;
                bit_cnt     <= '0;
                wait_cnt    <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        cmd_pin_oe  <= 1'b0;
                        cmd_pin_out <= 1'b1;
                        if (strobe_in) begin
                            tx_shift     <= cmd_to_send[38:0];
                            resp_none_q  <= (resp_type == RESP_NONE);
                            timeout_en_q <= timeout_enable;
                            rx_last      <= resp_len(resp_type) - 8'd1;
                            rx_shift     <= '0;
                            ack_out      <= 1'b1;
                            time_out     <= 1'b0;
                            bit_cnt      <= '0;
                            wait_cnt     <= '0;
                            cmd_pin_oe   <= 1'b1;
                            cmd_pin_out  <= cmd_to_send[39];
                            state        <= ST_SEND;
                        end
                    end

                    // bit_cnt is the index of the bit currently on the pin
                    ST_SEND: begin
                        bit_cnt <= bit_cnt + 8'd1;
                        if (bit_cnt < TX_BODY_LAST) begin
                            tx_shift    <= {tx_shift[37:0], 1'b0};
                            cmd_pin_out <= tx_shift[38];
                        end else if (bit_cnt < TX_END_IDX) begin
                            cmd_pin_out <= tx_crc[crc_idx];
                        end else begin
                            cmd_pin_out <= 1'b1;
                        end
                        if (bit_cnt == TX_LAST) begin
                            bit_cnt     <= '0;
                            wait_cnt    <= '0;
                            cmd_pin_out <= 1'b1;
                            cmd_pin_oe  <= resp_none_q;
                            state       <= resp_none_q ? ST_NCC_WAIT : ST_WAIT_RESP;
                        end
                    end

                    ST_WAIT_RESP: begin
                        if (!cmd_pin_in) begin
                            rx_shift <= rx_frame[126:0];
                            bit_cnt  <= 8'd1;
                            state    <= ST_RECV;
                        end else if (timeout_en_q && (wait_cnt == WAIT_LAST)) begin
                            time_out     <= 1'b1;
                            cmd_response <= '0;
                            strobe_out   <= 1'b1;
                            state        <= ST_DONE;
                        end else if (wait_cnt != WAIT_LAST) begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end

                    // A 128-bit window naturally drops the 8 header bits of a long reply
                    ST_RECV: begin
                        rx_shift <= rx_frame[126:0];
                        bit_cnt  <= bit_cnt + 8'd1;
                        if (rx_done) begin
                            cmd_response <= rx_frame;
                            strobe_out   <= 1'b1;
                            bit_cnt      <= '0;
                            state        <= ST_DONE;
                        end
                    end

                    ST_NCC_WAIT: begin
                        cmd_pin_oe  <= 1'b1;
                        cmd_pin_out <= 1'b1;
                        bit_cnt     <= bit_cnt + 8'd1;
                        if (bit_cnt == NCC_LAST) begin
                            cmd_pin_oe   <= 1'b0;
                            cmd_response <= '0;
                            strobe_out   <= 1'b1;
                            bit_cnt      <= '0;
                            state        <= ST_DONE;
                        end
                    end

                    ST_DONE: begin
                        cmd_pin_oe  <= 1'b0;
                        cmd_pin_out <= 1'b1;
                        if (ack_in) begin
                            strobe_out <= 1'b0;
                            state      <= ST_IDLE;
                        end
                    end

                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef RESP_CRC_CHECK_EN
    localparam logic [7:0] LONG_BODY_FIRST = 8'(LONG_RESP_LEN - 128);
    localparam logic [7:0] LONG_BODY_END   = 8'(LONG_RESP_LEN - 8);

    logic       rx_long;
    logic       rx_crc_en;
    logic [6:0] rx_crc;

    assign rx_long   = (rx_last == 8'(LONG_RESP_LEN - 1));
    // Short replies include the start bit (sampled in WAIT_RESP) in the CRC
    assign rx_crc_en = ((state == ST_WAIT_RESP) && !cmd_pin_in && !rx_long) ||
                       ((state == ST_RECV) &&
                        (rx_long ? ((bit_cnt >= LONG_BODY_FIRST) && (bit_cnt < LONG_BODY_END))
                                 : (bit_cnt < 8'(CMD_BODY_LEN))));

    crc7_serial u_rx_crc (
        .clock  (clock),
        .reset  (reset),
        .clear  (accept),
        .enable (rx_crc_en),
        .bit_in (cmd_pin_in),
        .crc    (rx_crc)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            crc_error <= 1'b0;
        end else if (accept) begin
            crc_error <= 1'b0;
        end else if (rx_done && !idle_in) begin
            crc_error <= (rx_crc != rx_frame[7:1]);
        end
    end
`else
    assign crc_error = 1'b0;
`endif

endmodule

// File: tb/tb_cmd_phys.sv
// Self-checking bench for cmd_phys: directed vector table, corner sequences, random traffic.
module tb_cmd_phys;

    localparam int unsigned TO  = 64;
    localparam int unsigned NCC = 8;
`ifdef RESP_CRC_CHECK_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         strobe_in = 1'b0;
    logic         ack_in = 1'b0;
    logic         idle_in = 1'b0;
    logic [39:0]  cmd_to_send = '0;
    logic [1:0]   resp_type = '0;
    logic         timeout_enable = 1'b0;
    logic         cmd_pin_in = 1'b1;
    logic         cmd_pin_out;
    logic         cmd_pin_oe;
    logic         ack_out;
    logic         strobe_out;
    logic [127:0] cmd_response;
    logic         time_out;
    logic         crc_error;

    int checks = 0;
    int errors = 0;

    cmd_phys #(.TIMEOUT_CYCLES(TO), .NCC_CYCLES(NCC)) dut (
        .clock          (clock),
        .reset          (reset),
        .strobe_in      (strobe_in),
        .ack_in         (ack_in),
        .idle_in        (idle_in),
        .cmd_to_send    (cmd_to_send),
        .resp_type      (resp_type),
        .timeout_enable (timeout_enable),
        .cmd_pin_in     (cmd_pin_in),
        .cmd_pin_out    (cmd_pin_out),
        .cmd_pin_oe     (cmd_pin_oe),
        .ack_out        (ack_out),
        .strobe_out     (strobe_out),
        .cmd_response   (cmd_response),
        .time_out       (time_out),
        .crc_error      (crc_error)
    );

    always #5 clock = ~clock;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic [39:0]  cmd;
        logic [1:0]   rtype;
        logic         ten;
        int           delay;
        logic [135:0] reply;
        logic [47:0]  ef;
        logic [127:0] er;
        logic         eto;
        logic         ecrc;
        int           elat;
    } vec_t;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1 (long division).
    function automatic logic [6:0] crc7_div(input logic [127:0] data, input int n);
        logic [134:0] v;
        v = 135'(data) << 7;
        for (int i = n + 6; i >= 7; i--)
            if (v[i]) v[i -: 8] = v[i -: 8] ^ 8'h89;
        return v[6:0];
    endfunction

    function automatic logic [47:0] tx_frame(input logic [39:0] cmd);
        return {cmd, crc7_div(128'(cmd), 40), 1'b1};
    endfunction

    function automatic vec_t mk(input logic [39:0] cmd, input logic [1:0] rtype, input logic ten,
                                input int delay, input logic [135:0] reply, input logic [47:0] ef,
                                input logic [127:0] er, input logic eto, input logic ecrc, input int elat);
        vec_t v;
        v.cmd = cmd; v.rtype = rtype; v.ten = ten; v.delay = delay; v.reply = reply;
        v.ef = ef; v.er = er; v.eto = eto; v.ecrc = ecrc; v.elat = elat;
        return v;
    endfunction

    // One command: send, card reply after 'delay' wait cycles, check result, ack.
    // elat = cycles from end of SEND to strobe_out; -1 means no strobe expected.
    task automatic run_txn(input vec_t v, input string tag);
        logic [47:0] frame;
        logic tx_bad, ack_bad, line_bad;
        int len, got, bound;
        len = (v.rtype == 2'b10) ? 136 : 48;
        cmd_to_send = v.cmd;
        resp_type = v.rtype;
        timeout_enable = v.ten;
        strobe_in = 1'b1;
        @(negedge clock);
        chk({tag, ".ack"}, 128'(ack_out), 128'(1));
        strobe_in = 1'b0;
        tx_bad = 1'b0; ack_bad = 1'b0; frame = '0;
        for (int k = 0; k < 48; k++) begin
            frame[47 - k] = cmd_pin_out;
            if (cmd_pin_oe !== 1'b1) tx_bad = 1'b1;
            if (k > 0 && ack_out !== 1'b0) ack_bad = 1'b1;
            @(negedge clock);
        end
        chk({tag, ".frame"}, 128'(frame), 128'(v.ef));
        chk({tag, ".tx_ctl"}, 128'({tx_bad, ack_bad}), 128'(0));
        got = -1; line_bad = 1'b0;
        bound = (v.elat >= 0) ? v.elat + 16 : 1000;
        for (int c = 0; c < bound; c++) begin
            if (strobe_out === 1'b1) begin
                got = c;
                break;
            end
            if (v.rtype == 2'b00) begin
                if (cmd_pin_oe !== 1'b1 || cmd_pin_out !== 1'b1) line_bad = 1'b1;
            end else if (cmd_pin_oe !== 1'b0) begin
                line_bad = 1'b1;
            end
            cmd_pin_in = (v.rtype != 2'b00 && c >= v.delay && c < v.delay + len)
                         ? v.reply[len - 1 - (c - v.delay)] : 1'b1;
            @(negedge clock);
        end
        cmd_pin_in = 1'b1;
        chk({tag, ".latency"}, 128'(got), 128'(v.elat));
        chk({tag, ".line"}, 128'(line_bad), 128'(0));
        if (v.elat < 0) return;
        if (got < 0) begin
            idle_in = 1'b1;
            @(negedge clock);
            idle_in = 1'b0;
            return;
        end
        chk({tag, ".resp"}, cmd_response, v.er);
        chk({tag, ".flags"}, 128'({time_out, crc_error}), 128'({v.eto, v.ecrc}));
        ack_in = 1'b1;
        @(negedge clock);
        chk({tag, ".strobe_drop"}, 128'(strobe_out), 128'(0));
        ack_in = 1'b0;
        chk({tag, ".resp_hold"}, cmd_response, v.er);
    endtask

    task automatic run_random(input int n);
        vec_t v;
        logic [119:0] body_l;
        logic [39:0]  body_s;
        logic [6:0]   c;
        logic         bad;
        int           len;
        for (int i = 0; i < n; i++) begin
            v.cmd   = {2'b01, 6'($urandom), 32'($urandom)};
            v.rtype = 2'($urandom);
            v.ten   = 1'($urandom);
            v.delay = $urandom_range(0, 70);
            bad     = ($urandom_range(0, 3) == 0);
            len     = (v.rtype == 2'b10) ? 136 : 48;
            if (v.rtype == 2'b10) begin
                body_l  = {24'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
                c       = crc7_div(128'(body_l), 120);
                if (bad) c = c ^ 7'(1 << $urandom_range(0, 6));
                v.reply = {8'h3F, body_l, c, 1'b1};
            end else begin
                body_s  = {2'b00, 6'($urandom), 32'($urandom)};
                c       = crc7_div(128'(body_s), 40);
                if (bad) c = c ^ 7'(1 << $urandom_range(0, 6));
                v.reply = {88'h0, body_s, c, 1'b1};
            end
            v.ef = tx_frame(v.cmd);
            if (v.rtype == 2'b00) begin
                v.elat = NCC; v.er = '0; v.eto = 1'b0; v.ecrc = 1'b0;
            end else if (v.ten && v.delay > int'(TO) - 1) begin
                v.elat = TO; v.er = '0; v.eto = 1'b1; v.ecrc = 1'b0;
            end else begin
                v.elat = v.delay + len;
                v.er   = (len == 48) ? 128'(v.reply[47:0]) : v.reply[127:0];
                v.eto  = 1'b0;
                v.ecrc = CRC_EN && bad;
            end
            run_txn(v, $sformatf("rnd%0d", i));
        end
    endtask

    localparam logic [135:0] R8_OK  = 136'h08000001AA13;
    localparam logic [135:0] R8_BAD = 136'h08000001AA15;

    vec_t vecs[9];
    logic [119:0] lbody;
    logic [127:0] lpay, lpay_bad;

    initial begin
        lbody    = 120'h0123456789ABCDEF_FEDCBA98765432;
        lpay     = {lbody, crc7_div(128'(lbody), 120), 1'b1};
        lpay_bad = {lbody, crc7_div(128'(lbody), 120) ^ 7'h01, 1'b1};
        vecs[0] = mk(40'h4000000000, 2'b00, 1'b1, 0, '0, 48'h400000000095, '0, 1'b0, 1'b0, NCC);
        vecs[1] = mk(40'h48000001AA, 2'b01, 1'b1, 5, R8_OK, 48'h48000001AA87, 128'(R8_OK[47:0]), 1'b0, 1'b0, 53);
        vecs[2] = mk(40'h48000001AA, 2'b01, 1'b1, 5, R8_BAD, 48'h48000001AA87, 128'(R8_BAD[47:0]), 1'b0, CRC_EN, 53);
        vecs[3] = mk(40'h48000001AA, 2'b01, 1'b1, 100000, '0, 48'h48000001AA87, '0, 1'b1, 1'b0, TO);
        vecs[4] = mk(40'h4200000000, 2'b10, 1'b1, 63, {8'h3F, lpay}, tx_frame(40'h4200000000), lpay, 1'b0, 1'b0, 63 + 136);
        vecs[5] = mk(40'h48000001AA, 2'b01, 1'b1, 63, R8_OK, 48'h48000001AA87, 128'(R8_OK[47:0]), 1'b0, 1'b0, 63 + 48);
        vecs[6] = mk(40'h48000001AA, 2'b01, 1'b1, 64, R8_OK, 48'h48000001AA87, '0, 1'b1, 1'b0, TO);
        vecs[7] = mk(40'h7712345678, 2'b11, 1'b0, 0, R8_OK, tx_frame(40'h7712345678), 128'(R8_OK[47:0]), 1'b0, 1'b0, 48);
        vecs[8] = mk(40'h4200000000, 2'b10, 1'b0, 2, {8'h3F, lpay_bad}, tx_frame(40'h4200000000), lpay_bad, 1'b0, CRC_EN, 2 + 136);

        repeat (3) @(negedge clock);
        chk("rst.pin", 128'(cmd_pin_out), 128'(1));
        chk("rst.ctl", 128'({cmd_pin_oe, ack_out, strobe_out, time_out, crc_error}), 128'(0));
        chk("rst.resp", cmd_response, '0);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 9; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // idle_in wins over strobe_in in IDLE
        cmd_to_send = 40'h4000000000; resp_type = 2'b00;
        strobe_in = 1'b1; idle_in = 1'b1;
        @(negedge clock);
        chk("prio.ack", 128'({ack_out, cmd_pin_oe}), 128'(0));
        strobe_in = 1'b0; idle_in = 1'b0;
        @(negedge clock);
        chk("prio.oe", 128'(cmd_pin_oe), 128'(0));

        // timeout disabled with the line held high: no completion, then abort
        run_txn(mk(40'h48000001AA, 2'b01, 1'b0, 100000, '0, 48'h48000001AA87, '0, 1'b0, 1'b0, -1), "hold");
        idle_in = 1'b1;
        @(negedge clock);
        idle_in = 1'b0;
        chk("abort.ctl", 128'({strobe_out, cmd_pin_oe, cmd_pin_out}), 128'(1));
        run_txn(vecs[0], "after_abort");

        // async reset in the middle of SEND
        cmd_to_send = 40'h48000001AA; resp_type = 2'b01; timeout_enable = 1'b1;
        strobe_in = 1'b1;
        @(negedge clock);
        strobe_in = 1'b0;
        repeat (20) @(negedge clock);
        chk("rst_mid.pre_oe", 128'(cmd_pin_oe), 128'(1));
        #1 reset = 1'b1;
        #1;
        chk("rst_mid.pin", 128'({cmd_pin_oe, cmd_pin_out}), 128'(1));
        chk("rst_mid.out", 128'({ack_out, strobe_out, time_out, crc_error}), 128'(0));
        chk("rst_mid.resp", cmd_response, '0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        run_txn(vecs[1], "after_rst");

        run_random(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmd_phys.md
Name: cmd_phys

Overview:
Physical-layer end of the SD host CMD path. It accepts a 40-bit command frame from the CMD controller and appends CRC7 and the end bit. It shifts the 48-bit frame onto the CMD pin MSB first, then receives the card response (none, 48-bit or 136-bit) or flags a timeout. It returns the response to the controller with a strobe/ack handshake.

Parameters:
TIMEOUT_CYCLES, 64, clocks to wait for a response start bit before declaring timeout (NCR)
NCC_CYCLES, 8, idle clocks driven high after a no-response command before completion

Ports:
clock  input  1  single system clock; one CMD bit per rising edge
reset  input  1  asynchronous, active-high reset
strobe_in  input  1  controller requests transmission; cmd_to_send valid
ack_in  input  1  controller has consumed cmd_response/time_out
idle_in  input  1  controller forces return to IDLE (abort)
cmd_to_send  input  40  {start 0, tx 1, index[5:0], argument[31:0]}
resp_type  input  2  00 none, 01 short (48 b), 10 long (136 b), 11 treated as short
timeout_enable  input  1  1 = enforce TIMEOUT_CYCLES; 0 = wait indefinitely
cmd_pin_in  input  1  sampled CMD line
cmd_pin_out  output  1  driven CMD line value
cmd_pin_oe  output  1  1 = drive CMD line
ack_out  output  1  one-cycle pulse: request accepted
strobe_out  output  1  result valid; held until ack_in
cmd_response  output  128  received response
time_out  output  1  no start bit within TIMEOUT_CYCLES
crc_error  output  1  response CRC7 mismatch (see Optional Feature)

Behaviour:
- Reset (async, active-high): state IDLE. All outputs 0 except cmd_pin_out=1. cmd_response=0.
- States: IDLE, SEND, WAIT_RESP, RECV, NCC_WAIT, DONE.
- IDLE: cmd_pin_oe=0, cmd_pin_out=1. When strobe_in=1, latch cmd_to_send, resp_type and timeout_enable, pulse ack_out for 1 cycle, clear time_out/crc_error, enter SEND.
- SEND: 48 cycles with oe=1. Cycles 0..39 drive the latched bits 39..0. CRC7 (poly x^7+x^3+1, init 0) is computed over those 40 bits. Cycles 40..46 drive CRC[6:0]. Cycle 47 drives 1. Next state is NCC_WAIT if resp_type=00, else WAIT_RESP.
- WAIT_RESP: oe=0. The counter starts at 0 on entry.
  - cmd_pin_in=0: that bit counts as response bit 0; go to RECV.
  - Counter reaches TIMEOUT_CYCLES-1 with timeout_enable=1 and no start bit: time_out=1, cmd_response=0, go to DONE.
  - A start bit in the same cycle as timeout expiry wins, and no timeout is raised.
- RECV: shift cmd_pin_in MSB first until 48 (short) or 136 (long) bits are collected, including the start bit.
  - Short: cmd_response[47:0] = frame, [127:48]=0.
  - Long: cmd_response = last 128 bits (the first 8 bits are discarded).
  - Go to DONE.
- NCC_WAIT: oe=1, drive 1 for NCC_CYCLES, then DONE with cmd_response=0.
- DONE: strobe_out=1. On ack_in=1, strobe_out drops the next cycle and the state returns to IDLE. cmd_response, time_out and crc_error stay stable until the next accepted request.
- idle_in=1 in any state: next cycle IDLE, oe=0, strobe_out=0, counters cleared. idle_in has priority over strobe_in.
- strobe_in while not IDLE is ignored.
- Command-to-completion latency: short = 48 + wait + 48 + 1 cycles; none = 48 + NCC_CYCLES + 1 cycles.

Optional Feature:
RESP_CRC_CHECK_EN.
- Defined: for short responses, CRC7 is computed over received bits 47..8 and compared with bits 7..1. For long responses, it is computed over the 120 bits preceding the CRC field of the 128-bit payload. crc_error is set in DONE on mismatch.
- Undefined: crc_error is tied to 0 and no receive CRC logic is built.

Decomposition:
- Package sd_cmd_pkg holds:
  - state encoding (one-hot, 6 bits)
  - RESP_NONE, RESP_SHORT, RESP_LONG constants
  - CMD_FRAME_LEN=48, LONG_RESP_LEN=136, CRC7_POLY=7'h09
- One sub-module crc7_serial, instantiated for TX and, under the macro, for RX. Ports: clock, reset, clear, enable, bit_in, crc[6:0].

Test Plan:
- CMD0, arg 0x00000000, resp_type=00: pin shows 48'h40_0000_0000_95, then 8 high bits. strobe_out asserts; ack_in returns to IDLE; time_out=0.
- CMD8, arg 0x000001AA, resp_type=01; card replies 48'h08_0000_01AA_13 after 5 cycles: pin shows 48'h48_0000_01AA_87, cmd_response=128'h0..08_0000_01AA_13, crc_error=0.
- Same as above with the reply's CRC byte corrupted to 0x15, macro defined: crc_error=1. Macro undefined: crc_error=0.
- resp_type=01, timeout_enable=1, line held high: time_out=1 and strobe_out=1 exactly TIMEOUT_CYCLES cycles after SEND ends, cmd_response=0. With timeout_enable=0: no strobe after 1000 cycles; idle_in returns to IDLE.
- CMD2, resp_type=10, 136-bit reply starting 8'h3F then a 128-bit payload P: cmd_response=P. Start bit arriving exactly on the timeout cycle is not a timeout.
- Async reset asserted mid-SEND (bit 20): outputs reset immediately, oe=0, pin=1. A new strobe_in after reset transmits correctly.
